// File: rtl/internet_tx_frag.sv
// ============================================================================
//  Module   : internet_tx_frag
//  Purpose  : IPv4 transmit layer. Builds a 20-byte header (no options),
//             copies the transport payload from a source RAM region into the
//             Ethernet frame buffer and fragments datagrams larger than
//             FRAG_BYTES using the MF flag and fragment offset field.
//  Ports    : clk/reset            - clock, synchronous active-high reset
//             sendDatagram ...     - request plus size/destination/protocol/DF
//             rdRAM/rdAddr/rdData/rdComplete - payload source read port
//             wrRAM/wrAddr/wrData/wrComplete - frame buffer write port
//             sendFrame/frameSize/frameSent  - hand-off to Ethernet TX
//             datagramSent/datagramError     - completion / rejection pulses
//             ARPIP                - latched destination for ARP lookup
//  Config   : IP_TX_DF_EN - when defined, dontFragment drives the DF bit and
//             oversize DF datagrams are rejected; otherwise DF is always 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module internet_tx_frag #(
  parameter logic [31:0] DEVICE_IP  = 32'h0a0105dd,
  parameter logic [7:0]  TTL        = 8'h40,
  parameter int unsigned FRAG_BYTES = 1480,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned SRC_BASE   = 0,
  parameter int unsigned HDR_BASE   = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sendDatagram,
  input  logic [15:0]       datagramSize,
  input  logic [31:0]       destinationIP,
  input  logic [7:0]        protocol,
  input  logic              dontFragment,
  output logic              rdRAM,
  output logic [ADDR_W-1:0] rdAddr,
  input  logic [7:0]        rdData,
  input  logic              rdComplete,
  output logic              wrRAM,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [7:0]        wrData,
  input  logic              wrComplete,
  output logic              sendFrame,
  output logic [10:0]       frameSize,
  input  logic              frameSent,
  output logic              datagramSent,
  output logic              datagramError,
  output logic [31:0]       ARPIP
);

  localparam logic [15:0]       c_fragBytes = 16'(FRAG_BYTES);
  localparam logic [15:0]       c_maxSize   = 16'd65515;
  localparam logic [ADDR_W-1:0] c_srcBase   = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] c_hdrBase   = ADDR_W'(HDR_BASE);
  localparam logic [ADDR_W-1:0] c_payBase   = ADDR_W'(HDR_BASE + 20);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_SET, S_HDR_WR, S_CKS_HI, S_CKS_LO, S_RD, S_WR, S_SEND, S_NEXT
  } state_t;

  state_t      r_state;
  logic [15:0] r_remaining;
  logic [15:0] r_offset;      // byte offset of current fragment
  logic [10:0] r_fragLen;
  logic        r_mf;
  logic        r_df;
  logic [15:0] r_iden;
  logic [15:0] r_idCnt;
  logic [7:0]  r_proto;
  logic [31:0] r_destIp;
  logic [4:0]  r_hdrIdx;
  logic [10:0] r_byteIdx;
  logic [7:0]  r_data;
  logic [15:0] r_cks;
  logic        r_datagramSent;
  logic        r_datagramError;

  logic        w_dfReq;
  logic        w_dfReject;
  logic [15:0] w_totLen;
  logic [7:0]  w_hdrByte;
  logic [15:0] w_word;
  logic [16:0] w_sum;
  logic [15:0] w_cksNext;
  logic        w_wrState;

`ifdef IP_TX_DF_EN
  assign w_dfReq    = dontFragment;
  assign w_dfReject = dontFragment && (datagramSize > c_fragBytes);
`else
  logic w_unused;
  assign w_dfReq    = 1'b0;
  assign w_dfReject = 1'b0;
  assign w_unused   = dontFragment;
`endif

  assign w_totLen = 16'd20 + {5'd0, r_fragLen};

  always_comb begin
    w_hdrByte = 8'h00;
    case (r_hdrIdx)
      5'd0:  w_hdrByte = 8'h45;
      5'd2:  w_hdrByte = w_totLen[15:8];
      5'd3:  w_hdrByte = w_totLen[7:0];
      5'd4:  w_hdrByte = r_iden[15:8];
      5'd5:  w_hdrByte = r_iden[7:0];
      5'd6:  w_hdrByte = {1'b0, r_df, r_mf, r_offset[15:11]};
      5'd7:  w_hdrByte = r_offset[10:3];
      5'd8:  w_hdrByte = TTL;
      5'd9:  w_hdrByte = r_proto;
      5'd12: w_hdrByte = DEVICE_IP[31:24];
      5'd13: w_hdrByte = DEVICE_IP[23:16];
      5'd14: w_hdrByte = DEVICE_IP[15:8];
      5'd15: w_hdrByte = DEVICE_IP[7:0];
      5'd16: w_hdrByte = r_destIp[31:24];
      5'd17: w_hdrByte = r_destIp[23:16];
      5'd18: w_hdrByte = r_destIp[15:8];
      5'd19: w_hdrByte = r_destIp[7:0];
      default: w_hdrByte = 8'h00;
    endcase
  end

  // Even header bytes are the high half of a 16-bit word; adding each byte
  // in its lane with end-around carry equals the one's-complement word sum.
  assign w_word    = r_hdrIdx[0] ? {8'h00, w_hdrByte} : {w_hdrByte, 8'h00};
  assign w_sum     = {1'b0, r_cks} + {1'b0, w_word};
  assign w_cksNext = w_sum[15:0] + {15'd0, w_sum[16]};

  assign w_wrState = (r_state == S_HDR_WR) || (r_state == S_CKS_HI) ||
                     (r_state == S_CKS_LO) || (r_state == S_WR);

  // Requests drop combinationally on the acknowledge cycle and on reset.
  assign wrRAM = w_wrState && !wrComplete && !reset;
  assign rdRAM = (r_state == S_RD) && !rdComplete && !reset;

  always_comb begin
    wrAddr = '0;
    wrData = 8'h00;
    case (r_state)
      S_HDR_WR: begin
        wrAddr = c_hdrBase + ADDR_W'(r_hdrIdx);
        wrData = w_hdrByte;
      end
      S_CKS_HI: begin
        wrAddr = c_hdrBase + ADDR_W'(10);
        wrData = ~r_cks[15:8];
      end
      S_CKS_LO: begin
        wrAddr = c_hdrBase + ADDR_W'(11);
        wrData = ~r_cks[7:0];
      end
      S_WR: begin
        wrAddr = c_payBase + ADDR_W'(r_byteIdx);
        wrData = r_data;
      end
      default: ;
    endcase
  end

  assign rdAddr = (r_state == S_RD) ?
                  (c_srcBase + ADDR_W'(r_offset) + ADDR_W'(r_byteIdx)) : '0;

  assign sendFrame     = (r_state == S_SEND);
  assign frameSize     = (r_state == S_SEND) ? (r_fragLen + 11'd20) : 11'd0;
  assign datagramSent  = r_datagramSent;
  assign datagramError = r_datagramError;
  assign ARPIP         = r_destIp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_remaining     <= '0;
      r_offset        <= '0;
      r_fragLen       <= '0;
      r_mf            <= 1'b0;
      r_df            <= 1'b0;
      r_iden          <= '0;
      r_idCnt         <= '0;
      r_proto         <= '0;
      r_destIp        <= '0;
      r_hdrIdx        <= '0;
      r_byteIdx       <= '0;
      r_data          <= '0;
      r_cks           <= '0;
      r_datagramSent  <= 1'b0;
      r_datagramError <= 1'b0;
    end else begin
      r_datagramSent  <= 1'b0;
      r_datagramError <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sendDatagram) begin
            if ((datagramSize > c_maxSize) || w_dfReject) begin
              r_datagramError <= 1'b1;
            end else begin
              r_remaining <= datagramSize;
              r_destIp    <= destinationIP;
              r_proto     <= protocol;
              r_df        <= w_dfReq;
              r_offset    <= '0;
              r_iden      <= r_idCnt;
              r_idCnt     <= r_idCnt + 16'd1;
              r_state     <= S_HDR_SET;
            end
          end
        end
        S_HDR_SET: begin
          if (r_remaining > c_fragBytes) begin
            r_fragLen <= c_fragBytes[10:0];
            r_mf      <= 1'b1;
          end else begin
            r_fragLen <= r_remaining[10:0];
            r_mf      <= 1'b0;
          end
          r_cks     <= '0;
          r_hdrIdx  <= '0;
          r_byteIdx <= '0;
          r_state   <= S_HDR_WR;
        end
        S_HDR_WR: begin
          if (wrComplete) begin
            r_cks <= w_cksNext;
            if (r_hdrIdx == 5'd19) r_state  <= S_CKS_HI;
            else                   r_hdrIdx <= r_hdrIdx + 5'd1;
          end
        end
        S_CKS_HI: begin
          if (wrComplete) r_state <= S_CKS_LO;
        end
        S_CKS_LO: begin
          if (wrComplete) r_state <= (r_fragLen == 11'd0) ? S_SEND : S_RD;
        end
        S_RD: begin
          if (rdComplete) begin
            r_data  <= rdData;
            r_state <= S_WR;
          end
        end
        S_WR: begin
          if (wrComplete) begin
            if (r_byteIdx == (r_fragLen - 11'd1)) begin
              r_state <= S_SEND;
            end else begin
              r_byteIdx <= r_byteIdx + 11'd1;
              r_state   <= S_RD;
            end
          end
        end
        S_SEND: begin
          if (frameSent) r_state <= S_NEXT;
        end
        S_NEXT: begin
          r_offset    <= r_offset + {5'd0, r_fragLen};
          r_remaining <= r_remaining - {5'd0, r_fragLen};
          if (r_remaining == {5'd0, r_fragLen}) begin
            r_datagramSent <= 1'b1;
            r_state        <= S_IDLE;
          end else begin
            r_state <= S_HDR_SET;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_internet_tx_frag.sv
// ============================================================================
//  Module   : tb_internet_tx_frag
//  Purpose  : Self-checking bench for internet_tx_frag. RAM responders with
//             random acknowledge delays, a header/checksum reference model
//             and per-frame payload/write-count checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_internet_tx_frag;

  localparam int          FRAG   = 1480;
  localparam int          HB     = 14;
  localparam int          MEMN   = 2048;
  localparam logic [31:0] DEV_IP = 32'h0a0105dd;
  localparam logic [7:0]  TTL_V  = 8'h40;

  logic        clk = 1'b0;
  logic        reset;
  logic        sendDatagram;
  logic [15:0] datagramSize;
  logic [31:0] destinationIP;
  logic [7:0]  protocol;
  logic        dontFragment;
  logic        rdRAM;
  logic [10:0] rdAddr;
  logic [7:0]  rdData;
  logic        rdComplete;
  logic        wrRAM;
  logic [10:0] wrAddr;
  logic [7:0]  wrData;
  logic        wrComplete;
  logic        sendFrame;
  logic [10:0] frameSize;
  logic        frameSent;
  logic        datagramSent;
  logic        datagramError;
  logic [31:0] ARPIP;

  internet_tx_frag dut (
    .clk(clk), .reset(reset), .sendDatagram(sendDatagram),
    .datagramSize(datagramSize), .destinationIP(destinationIP),
    .protocol(protocol), .dontFragment(dontFragment),
    .rdRAM(rdRAM), .rdAddr(rdAddr), .rdData(rdData), .rdComplete(rdComplete),
    .wrRAM(wrRAM), .wrAddr(wrAddr), .wrData(wrData), .wrComplete(wrComplete),
    .sendFrame(sendFrame), .frameSize(frameSize), .frameSent(frameSent),
    .datagramSent(datagramSent), .datagramError(datagramError), .ARPIP(ARPIP)
  );

  always #5 clk = ~clk;

  logic [7:0] srcMem [MEMN];
  logic [7:0] fb     [MEMN];
  int         wcount [MEMN];
  int         wcBase [MEMN];
  int totalWrites = 0, totalReads = 0, wrBase = 0, rdBase = 0;
  int maxDelay = 0;
  int checks = 0, failures = 0;
  int expIden = 0;

  // Write responder: acknowledges after 0..maxDelay cycles, records the byte.
  int  wrCnt = 0;
  bit  wrPend = 0;
  always @(negedge clk) begin
    if (reset) begin
      wrComplete = 1'b0; wrPend = 0;
    end else if (wrComplete) begin
      wrComplete = 1'b0;
    end else if (wrRAM) begin
      if (!wrPend) begin wrPend = 1; wrCnt = $urandom_range(0, maxDelay); end
      if (wrCnt == 0) begin
        fb[wrAddr] = wrData;
        wcount[wrAddr] = wcount[wrAddr] + 1;
        totalWrites = totalWrites + 1;
        wrComplete = 1'b1; wrPend = 0;
      end else wrCnt = wrCnt - 1;
    end
  end

  // Read responder: returns source RAM contents after a random delay.
  int  rdCnt = 0;
  bit  rdPend = 0;
  always @(negedge clk) begin
    if (reset) begin
      rdComplete = 1'b0; rdPend = 0;
    end else if (rdComplete) begin
      rdComplete = 1'b0;
    end else if (rdRAM) begin
      if (!rdPend) begin rdPend = 1; rdCnt = $urandom_range(0, maxDelay); end
      if (rdCnt == 0) begin
        rdData = srcMem[rdAddr];
        totalReads = totalReads + 1;
        rdComplete = 1'b1; rdPend = 0;
      end else rdCnt = rdCnt - 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference header: fields laid out from the datagram parameters, checksum
  // computed as the one's complement of the folded 16-bit word sum.
  function automatic logic [159:0] modelHdr(input int totLen, input int iden,
      input int dfb, input int mfb, input int offBytes, input int proto,
      input logic [31:0] ip);
    logic [7:0]  h [20];
    logic [31:0] dev;
    logic [15:0] cks;
    logic [159:0] r;
    int s;
    int off8;
    dev  = DEV_IP;
    off8 = offBytes / 8;
    h[0] = 8'h45; h[1] = 8'h00;
    h[2] = totLen[15:8]; h[3] = totLen[7:0];
    h[4] = iden[15:8];   h[5] = iden[7:0];
    h[6] = {1'b0, dfb[0], mfb[0], off8[12:8]};
    h[7] = off8[7:0];
    h[8] = TTL_V; h[9] = proto[7:0];
    h[10] = 8'h00; h[11] = 8'h00;
    h[12] = dev[31:24]; h[13] = dev[23:16]; h[14] = dev[15:8]; h[15] = dev[7:0];
    h[16] = ip[31:24];  h[17] = ip[23:16];  h[18] = ip[15:8];  h[19] = ip[7:0];
    s = 0;
    for (int i = 0; i < 10; i++) s = s + {h[2*i], h[2*i+1]};
    while (s > 65535) s = (s & 65535) + (s >> 16);
    cks = ~s[15:0];
    h[10] = cks[15:8]; h[11] = cks[7:0];
    r = '0;
    for (int i = 0; i < 20; i++) r = {r[151:0], h[i]};
    return r;
  endfunction

  task automatic snapshot();
    for (int a = 0; a < MEMN; a++) wcBase[a] = wcount[a];
    wrBase = totalWrites;
  endtask

  task automatic sendReq(input int size, input int proto, input logic [31:0] ip, input int df);
    @(negedge clk);
    datagramSize  = size[15:0];
    protocol      = proto[7:0];
    destinationIP = ip;
    dontFragment  = df[0];
    sendDatagram  = 1'b1;
    @(negedge clk);
    sendDatagram  = 1'b0;
  endtask

  task automatic checkFrame(input int size, input int k, input int proto,
      input logic [31:0] ip, input int dfEff, input int iden, output bit ok);
    logic [159:0] obs;
    int off, rem, L, mf, bad, s;
    bit seen;
    seen = 0;
    for (int c = 0; c < 60000; c++) begin
      @(negedge clk);
      if (sendFrame) begin seen = 1; break; end
    end
    ok = seen;
    if (!seen) begin
      chk("sendFrame_timeout", {159'd0, sendFrame}, 160'd1);
      return;
    end
    off = k * FRAG;
    rem = size - off;
    L   = (rem > FRAG) ? FRAG : rem;
    mf  = (rem > FRAG) ? 1 : 0;
    chk("frameSize", {149'd0, frameSize}, 20 + L);
    obs = '0;
    for (int i = 0; i < 20; i++) obs = {obs[151:0], fb[HB+i]};
    chk("header", obs, modelHdr(20 + L, iden, dfEff, mf, off, proto, ip));
    s = 0;
    for (int i = 0; i < 10; i++) s = s + {fb[HB+2*i], fb[HB+2*i+1]};
    while (s > 65535) s = (s & 65535) + (s >> 16);
    chk("checksum_verify", s, 16'hFFFF);
    bad = 0;
    for (int j = 0; j < L; j++) begin
      if (fb[HB+20+j] !== srcMem[(off + j) % MEMN]) bad++;
      if (wcount[HB+20+j] - wcBase[HB+20+j] != 1) bad++;
    end
    chk("payload_bad_bytes", bad, 0);
    chk("write_count", totalWrites - wrBase, 22 + L);
  endtask

  task automatic ackFrame();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    frameSent = 1'b1;
    @(negedge clk);
    frameSent = 1'b0;
    snapshot();
  endtask

  task automatic runDatagram(input int size, input int proto, input logic [31:0] ip,
      input int df, input bit spurious);
    int  nfr, dfEff;
    bit  ok, seen;
`ifdef IP_TX_DF_EN
    dfEff = df;
`else
    dfEff = 0;
`endif
    nfr = (size == 0) ? 1 : (size + FRAG - 1) / FRAG;
    snapshot();
    rdBase = totalReads;
    sendReq(size, proto, ip, df);
    for (int k = 0; k < nfr; k++) begin
      checkFrame(size, k, proto, ip, dfEff, expIden, ok);
      if (!ok) return;
      if (k == 0) chk("ARPIP", {128'd0, ARPIP}, {128'd0, ip});
      if (spurious && k == 0) begin
        datagramSize = 16'd5;
        sendDatagram = 1'b1;
        @(negedge clk);
        sendDatagram = 1'b0;
      end
      ackFrame();
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (datagramSent) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("datagramSent", {159'd0, seen}, 160'd1);
    expIden++;
  endtask

  initial begin
    bit ok, seen;
    reset = 1'b1; sendDatagram = 1'b0; datagramSize = '0; destinationIP = '0;
    protocol = '0; dontFragment = 1'b0; frameSent = 1'b0;
    wrComplete = 1'b0; rdComplete = 1'b0; rdData = '0;
    for (int a = 0; a < MEMN; a++) begin
      srcMem[a] = 8'($urandom); fb[a] = 8'h00; wcount[a] = 0; wcBase[a] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {104'd0, wrRAM, rdRAM, sendFrame, datagramSent, datagramError, frameSize, ARPIP},
        160'd0);
    reset = 1'b0;

    // Empty datagram: single 20-byte frame, no payload reads.
    maxDelay = 0;
    runDatagram(0, 17, 32'hc0a80001, 0, 0);
    chk("no_reads_size0", totalReads - rdBase, 0);

    // Three fragments 1500/1500/60, offsets 0/185/370.
    runDatagram(3000, 6, 32'h0a000002, 0, 0);

    // Back to back; a request while busy must be dropped.
    runDatagram(100, 1, 32'h0a000003, 0, 1);
    snapshot();
    repeat (10) @(negedge clk);
    chk("busy_request_ignored", {158'd0, sendFrame, 1'b0} | (totalWrites - wrBase), 0);
    runDatagram(1480, 17, 32'h0a000004, 0, 0);
    runDatagram(1481, 17, 32'h0a000005, 0, 0);

    // Random sizes with random acknowledge delays.
    maxDelay = 7;
    for (int n = 0; n < 2; n++)
      runDatagram($urandom_range(1, 1700), $urandom_range(0, 255), $urandom, 0, 0);
    maxDelay = 0;

    // Oversize datagram is rejected with a one-cycle error pulse.
    snapshot();
    sendReq(65516, 17, 32'h0a000006, 0);
    chk("err_pulse", {159'd0, datagramError}, 160'd1);
    @(negedge clk);
    chk("err_one_cycle", {159'd0, datagramError}, 160'd0);
    repeat (5) @(negedge clk);
    chk("err_no_writes", totalWrites - wrBase, 0);

`ifdef IP_TX_DF_EN
    snapshot();
    sendReq(2000, 17, 32'h0a000007, 1);
    chk("df_err_pulse", {159'd0, datagramError}, 160'd1);
    repeat (5) @(negedge clk);
    chk("df_err_no_writes", totalWrites - wrBase, 0);
    runDatagram(100, 17, 32'h0a000008, 1, 0);
`else
    runDatagram(1500, 17, 32'h0a000009, 1, 0);
`endif

    // Reset during payload writes of the second fragment.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    expIden = 0;
    maxDelay = 3;
    snapshot();
    sendReq(3000, 17, 32'h0a00000a, 0);
    checkFrame(3000, 0, 17, 32'h0a00000a, 0, 0, ok);
    if (ok) begin
      ackFrame();
      seen = 0;
      for (int c = 0; c < 5000; c++) begin
        @(negedge clk);
        if (wrAddr >= 11'(HB + 20)) begin seen = 1; break; end
      end
      chk("reached_frag2_payload", {159'd0, seen}, 160'd1);
      reset = 1'b1;
      #1;
      chk("req_drop_on_reset", {158'd0, wrRAM, rdRAM}, 160'd0);
      @(negedge clk);
      chk("outputs_after_reset",
          {104'd0, wrRAM, rdRAM, sendFrame, datagramSent, datagramError, frameSize, ARPIP},
          160'd0);
      reset = 1'b0;
      maxDelay = 0;
      runDatagram(50, 17, 32'h0a00000b, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
